// File: rtl/snake_matrix.sv
// Snake game engine for an LED dot matrix: shift-register body, tick-driven steps,
// turn/grow/pause handling, self-collision detection and a registered row-scanned display.
module snake_matrix #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned LEN_INIT = 3,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    turn_left,
  input  logic                    turn_right,
  input  logic                    grow,
  input  logic                    pause,
  input  logic                    restart,
  output logic [ROWS-1:0]         display_row,
  output logic [COLS-1:0]         display_col,
  output logic [$clog2(COLS)-1:0] head_x,
  output logic [$clog2(ROWS)-1:0] head_y,
  output logic [5:0]              length,
  output logic                    dead
);

  localparam int unsigned XW = $clog2(COLS);
  localparam int unsigned YW = $clog2(ROWS);
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {RUN, PAUSE, DEAD} state_t;

  state_t          state, state_next;
  logic [XW-1:0]   seg_x [MAX_LEN];
  logic [YW-1:0]   seg_y [MAX_LEN];
  logic [5:0]      len;
  logic [1:0]      dir;
  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   scan_cnt;
  logic [YW-1:0]   scan_row;
  logic            turn_pend, turn_rpend, grow_pend, blink_off;

  logic            tick_en, tick, step, turn_now, turn_r, grow_ok, collide;
  logic [1:0]      dir_eff;
  logic [XW-1:0]   nx;
  logic [YW-1:0]   ny;
  logic [5:0]      chk_lim;
  logic [COLS-1:0] pix;

  function automatic logic [XW-1:0] init_x(input int unsigned i);
    return (i < LEN_INIT) ? XW'(LEN_INIT - 1 - i) : '0;
  endfunction

  always_comb begin
    state_next = state;
    // The counter keeps running in DEAD so the blink phase has a time base.
    tick_en  = (state == DEAD) || !pause;
    tick     = tick_en && (tick_cnt == TW'(TICK_DIV - 1));
    step     = tick && (state != DEAD) && !restart;
    turn_now = turn_left ^ turn_right;
    turn_r   = turn_now ? turn_right : turn_rpend;
    dir_eff  = dir;
    if (turn_now || turn_pend)
      dir_eff = turn_r ? dir + 2'd1 : dir - 2'd1;
    grow_ok = (grow || grow_pend) && (len < 6'(MAX_LEN));
    nx = seg_x[0];
    ny = seg_y[0];
    case (dir_eff)
      2'd0: nx = (seg_x[0] == XW'(COLS - 1)) ? '0 : seg_x[0] + XW'(1);
      2'd1: ny = (seg_y[0] == YW'(ROWS - 1)) ? '0 : seg_y[0] + YW'(1);
      2'd2: nx = (seg_x[0] == '0) ? XW'(COLS - 1) : seg_x[0] - XW'(1);
      default: ny = (seg_y[0] == '0) ? YW'(ROWS - 1) : seg_y[0] - YW'(1);
    endcase
    // The tail only counts as an obstacle when it will not vacate this step.
    chk_lim = grow_ok ? len : len - 6'd1;
    collide = 1'b0;
    for (int unsigned i = 1; i < MAX_LEN; i++)
      if ((6'(i) < chk_lim) && (seg_x[i] == nx) && (seg_y[i] == ny))
        collide = 1'b1;
    if (restart)
      state_next = RUN;
    else begin
      case (state)
        RUN, PAUSE: begin
          if (step && collide) state_next = DEAD;
          else if (pause)      state_next = PAUSE;
          else                 state_next = RUN;
        end
        default: state_next = DEAD;
      endcase
    end
  end

  always_comb begin
    pix = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++)
      if ((6'(i) < len) && (seg_y[i] == scan_row))
        for (int unsigned x = 0; x < COLS; x++)
          if (seg_x[i] == XW'(x)) pix[x] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= '0;
      end
      len <= 6'(LEN_INIT);
      dir <= '0;
    end else if (restart) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= '0;
      end
      len <= 6'(LEN_INIT);
      dir <= '0;
    end else if (step && !collide) begin
      seg_x[0] <= nx;
      seg_y[0] <= ny;
      for (int unsigned i = 1; i < MAX_LEN; i++) begin
        seg_x[i] <= seg_x[i-1];
        seg_y[i] <= seg_y[i-1];
      end
      dir <= dir_eff;
      if (grow_ok) len <= len + 6'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      tick_cnt   <= '0;
      turn_pend  <= 1'b0;
      turn_rpend <= 1'b0;
      grow_pend  <= 1'b0;
      blink_off  <= 1'b0;
    end else if (restart) begin
      state      <= RUN;
      tick_cnt   <= '0;
      turn_pend  <= 1'b0;
      turn_rpend <= 1'b0;
      grow_pend  <= 1'b0;
      blink_off  <= 1'b0;
    end else begin
      state <= state_next;
      if (tick_en) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (step) begin
        turn_pend <= 1'b0;
        grow_pend <= 1'b0;
      end else begin
        if (turn_now) begin
          turn_pend  <= 1'b1;
          turn_rpend <= turn_right;
        end
        if (grow) grow_pend <= 1'b1;
      end
      if (state_next != DEAD)         blink_off <= 1'b0;
      else if ((state == DEAD) && tick) blink_off <= ~blink_off;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt    <= '0;
      scan_row    <= '0;
      display_row <= ROWS'(1);
      display_col <= '0;
    end else if (restart) begin
      scan_cnt    <= '0;
      scan_row    <= '0;
      display_row <= ROWS'(1);
      display_col <= '0;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_row <= (scan_row == YW'(ROWS - 1)) ? '0 : scan_row + YW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      display_row <= ROWS'(1) << scan_row;
      display_col <= ((state == DEAD) && blink_off) ? '0 : pix;
    end
  end

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  assign length = len;
  assign dead   = (state == DEAD);

endmodule

// File: tb/tb_snake_matrix.sv
// Bench for snake_matrix: queue-based model of the snake, expectations queued at each
// stimulus step and compared against the DUT once the step edge has passed.
module tb_snake_matrix;

  localparam int unsigned ROWS = 8, COLS = 8, LEN_INIT = 3, MAX_LEN = 8;
  localparam int unsigned TICK_DIV = 4, SCAN_DIV = 2;

  logic clock = 1'b0, reset, turn_left, turn_right, grow, pause, restart;
  logic [ROWS-1:0] display_row;
  logic [COLS-1:0] display_col;
  logic [2:0] head_x, head_y;
  logic [5:0] length;
  logic dead;

  snake_matrix #(
    .ROWS(ROWS), .COLS(COLS), .LEN_INIT(LEN_INIT), .MAX_LEN(MAX_LEN),
    .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clock(clock), .reset(reset), .turn_left(turn_left), .turn_right(turn_right),
    .grow(grow), .pause(pause), .restart(restart), .display_row(display_row),
    .display_col(display_col), .head_x(head_x), .head_y(head_y), .length(length),
    .dead(dead)
  );

  always #5 clock = ~clock;

  int unsigned cyc;
  always @(posedge clock or posedge reset)
    if (reset)        cyc <= 0;
    else if (restart) cyc <= 0;
    else              cyc <= cyc + 1;

  typedef enum {K_HX, K_HY, K_LEN, K_DEAD, K_ROW, K_COL} kind_e;
  typedef struct {string tag; kind_e kind; int unsigned val;} exp_t;
  exp_t sb[$];
  int unsigned n_checks = 0, n_err = 0;

  int unsigned mx[$], my[$];
  int unsigned mdir;
  bit mdead;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int unsigned observe(input kind_e k);
    case (k)
      K_HX:    return int'(head_x);
      K_HY:    return int'(head_y);
      K_LEN:   return int'(length);
      K_DEAD:  return int'(dead);
      K_ROW:   return int'(display_row);
      default: return int'(display_col);
    endcase
  endfunction

  task automatic push(input string tag, input kind_e k, input int unsigned v);
    exp_t e;
    e.tag = tag; e.kind = k; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.kind), e.val);
    end
  endtask

  function automatic void model_reset();
    mx.delete(); my.delete();
    for (int i = 0; i < int'(LEN_INIT); i++) begin
      mx.push_back(LEN_INIT - 1 - i);
      my.push_back(0);
    end
    mdir = 0; mdead = 0;
  endfunction

  // turn: 0 none, 1 right, 2 left
  function automatic void model_step(input int unsigned turn, input bit g);
    int unsigned nd, nx, ny;
    int last;
    bit grows, hit;
    if (mdead) return;
    nd = (turn == 1) ? (mdir + 1) % 4 : (turn == 2) ? (mdir + 3) % 4 : mdir;
    nx = mx[0]; ny = my[0];
    case (nd)
      0: nx = (nx + 1) % COLS;
      1: ny = (ny + 1) % ROWS;
      2: nx = (nx + COLS - 1) % COLS;
      default: ny = (ny + ROWS - 1) % ROWS;
    endcase
    grows = g && (mx.size() < MAX_LEN);
    last = grows ? mx.size() - 1 : mx.size() - 2;
    hit = 0;
    for (int i = 1; i <= last; i++)
      if (mx[i] == nx && my[i] == ny) hit = 1;
    if (hit) begin
      mdead = 1;
      return;
    end
    mdir = nd;
    mx.push_front(nx); my.push_front(ny);
    if (!grows) begin
      void'(mx.pop_back()); void'(my.pop_back());
    end
  endfunction

  function automatic int unsigned model_pix(input int unsigned row);
    int unsigned p = 0;
    for (int i = 0; i < mx.size(); i++)
      if (my[i] == row) p |= (1 << mx[i]);
    return p;
  endfunction

  task automatic push_state(input string tag);
    push({tag, ".hx"}, K_HX, mx[0]);
    push({tag, ".hy"}, K_HY, my[0]);
    push({tag, ".len"}, K_LEN, mx.size());
    push({tag, ".dead"}, K_DEAD, mdead);
  endtask

  task automatic push_reset_vals(input string tag);
    push({tag, ".hx"}, K_HX, LEN_INIT - 1);
    push({tag, ".hy"}, K_HY, 0);
    push({tag, ".len"}, K_LEN, LEN_INIT);
    push({tag, ".dead"}, K_DEAD, 0);
    push({tag, ".row"}, K_ROW, 1);
    push({tag, ".col"}, K_COL, 0);
  endtask

  // From a period start (tick counter 0): pulse in the first or the strobe cycle, then step.
  task automatic do_step(input string tag, input bit tl, input bit tr, input bit g, input bit late);
    if (late) repeat (3) @(negedge clock);
    turn_left = tl; turn_right = tr; grow = g;
    @(negedge clock);
    turn_left = 0; turn_right = 0; grow = 0;
    if (!late) repeat (3) @(negedge clock);
    model_step((tl && !tr) ? 2 : (tr && !tl) ? 1 : 0, g);
    push_state(tag);
    drain();
  endtask

  int unsigned cyc_d, row, k;

  initial begin
    reset = 1; turn_left = 0; turn_right = 0; grow = 0; pause = 0; restart = 0;
    model_reset();
    #2;
    push_reset_vals("rst");
    drain();
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    push("rst1.row", K_ROW, 1);
    push("rst1.col", K_COL, 32'h07);
    drain();
    repeat (3) @(negedge clock);
    model_step(0, 0);
    push_state("step1");
    drain();
    for (int i = 0; i < 4; i++) do_step("run", 0, 0, 0, 0);
    push("five.hx", K_HX, 7);
    drain();
    do_step("wrap", 0, 0, 0, 0);
    push("wrap.hx", K_HX, 0);
    drain();

    do_step("turn_r", 0, 1, 0, 0);
    // pending left, then a simultaneous left+right cycle that must leave it intact
    turn_left = 1;
    @(negedge clock);
    turn_right = 1;
    @(negedge clock);
    turn_left = 0; turn_right = 0;
    repeat (2) @(negedge clock);
    model_step(2, 0);
    push_state("keep_l");
    drain();
    do_step("both", 1, 1, 0, 0);
    do_step("late_r", 0, 1, 0, 1);
    do_step("late_l", 1, 0, 0, 1);
    do_step("up", 1, 0, 0, 0);
    do_step("up", 0, 0, 0, 0);
    do_step("upwrap", 0, 0, 0, 0);
    push("upwrap.hy", K_HY, 7);
    drain();

    @(negedge clock);
    pause = 1;
    repeat (3) @(negedge clock);
    turn_right = 1;
    @(negedge clock);
    turn_right = 0;
    repeat (6) @(negedge clock);
    pause = 0;
    repeat (2) @(negedge clock);
    push_state("pause_hold");
    drain();
    @(negedge clock);
    model_step(1, 0);
    push_state("pause_step");
    drain();

    restart = 1;
    @(negedge clock);
    restart = 0;
    model_reset();
    push_reset_vals("restart");
    drain();

    for (int i = 0; i < 20; i++) do_step("grow", 0, 0, 1, 0);
    push("len_sat", K_LEN, MAX_LEN);
    drain();

    // restart on the strobe cycle must win over the step
    repeat (3) @(negedge clock);
    restart = 1;
    @(negedge clock);
    restart = 0;
    model_reset();
    push_reset_vals("restart_tick");
    drain();

    do_step("g5", 0, 0, 1, 0);
    do_step("g5", 0, 0, 1, 0);
    do_step("down", 0, 1, 0, 0);
    do_step("left", 0, 1, 0, 0);
    do_step("up_hit", 0, 1, 0, 0);
    push("hit.dead", K_DEAD, 1);
    push("hit.len", K_LEN, 5);
    drain();
    cyc_d = cyc;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      k = cyc - cyc_d;
      row = ((cyc - 1) / 2) % ROWS;
      push("blink.row", K_ROW, 1 << row);
      push("blink.col", K_COL, (((k - 1) / 4) % 2 == 0) ? model_pix(row) : 0);
      drain();
    end
    push_state("frozen");
    drain();

    @(negedge clock);
    #2 reset = 1;
    #1;
    push_reset_vals("async_rst");
    drain();
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    push("post_rst.dead", K_DEAD, 0);
    push("post_rst.col", K_COL, 32'h07);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
